// File: rtl/simd_pkg.sv
// Shared definitions for the SIMD vector datapath and its memory-side units.
// Holds the vector geometry plus the types used by the vector store path.
package simd_pkg;

    localparam int WIDTH_V      = 128;
    localparam int BITS_INDEX   = 8;
    localparam int NUM_ELEMENTS = WIDTH_V / BITS_INDEX;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WRITE = 2'd1,
        ST_DONE  = 2'd2
    } store_state_t;

    typedef logic [BITS_INDEX-1:0] element_t;

endpackage

// File: rtl/vector_unpack_shift.sv
// Loadable left-shift register that presents the most significant element of a
// packed vector; each shift exposes the next element (element 0 sits in the MSBs).
module vector_unpack_shift #(
    parameter int WIDTH  = 128,
    parameter int ELEM_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic              shift,
    input  logic [WIDTH-1:0]  data,
    output logic [ELEM_W-1:0] head
);

    logic [WIDTH-1:0] shreg;

    // Load wins over shift so a fresh vector never loses its first element.
    always_ff @(posedge clk) begin
        if (rst) begin
            shreg <= '0;
        end else if (load) begin
            shreg <= data;
        end else if (shift) begin
            shreg <= {shreg[WIDTH-ELEM_W-1:0], {ELEM_W{1'b0}}};
        end
    end

    assign head = shreg[WIDTH-1 -: ELEM_W];

endmodule

// File: rtl/vector_store_unit.sv
// Stores one packed SIMD vector to byte-wide memory, one element per accepted
// beat, starting at a latched base address; signals completion with a done pulse.
module vector_store_unit
    import simd_pkg::*;
#(
    parameter int WIDTH_V    = simd_pkg::WIDTH_V,
    parameter int BITS_INDEX = simd_pkg::BITS_INDEX,
    parameter int ADDR_W     = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [ADDR_W-1:0]     base_addr,
    input  logic [WIDTH_V-1:0]    vec_in,
    output logic                  busy,
    output logic                  done,
    output logic                  mem_we,
    output logic [ADDR_W-1:0]     mem_addr,
    output logic [BITS_INDEX-1:0] mem_wdata,
    input  logic                  mem_ready
);

    localparam int NUM_ELEMENTS = WIDTH_V / BITS_INDEX;
    localparam int CNT_W        = $clog2(NUM_ELEMENTS);
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(NUM_ELEMENTS - 1);

    store_state_t     state;
    logic [CNT_W-1:0] count;
    logic             load_vec;
    logic             accept;

    assign load_vec = (state == ST_IDLE) && start;
    assign accept   = (state == ST_WRITE) && mem_ready;

    vector_unpack_shift #(
        .WIDTH  (WIDTH_V),
        .ELEM_W (BITS_INDEX)
    ) u_unpack (
        .clk   (clk),
        .rst   (rst),
        .load  (load_vec),
        .shift (accept),
        .data  (vec_in),
        .head  (mem_wdata)
    );

    // mem_addr doubles as the running address, so base_addr needs no separate latch.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ST_IDLE;
            busy     <= 1'b0;
            done     <= 1'b0;
            mem_we   <= 1'b0;
            mem_addr <= '0;
            count    <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        state    <= ST_WRITE;
                        busy     <= 1'b1;
                        mem_we   <= 1'b1;
                        mem_addr <= base_addr;
                        count    <= '0;
                    end
                end
                ST_WRITE: begin
                    if (mem_ready) begin
                        if (count == LAST_IDX) begin
                            state  <= ST_DONE;
                            mem_we <= 1'b0;
                            done   <= 1'b1;
                        end else begin
                            count    <= count + 1'b1;
                            mem_addr <= mem_addr + ADDR_W'(1);
                        end
                    end
                end
                ST_DONE: begin
                    state <= ST_IDLE;
                    done  <= 1'b0;
                    busy  <= 1'b0;
                end
                default: begin
                    state  <= ST_IDLE;
                    busy   <= 1'b0;
                    done   <= 1'b0;
                    mem_we <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_vector_store_unit.sv
// Self-checking bench for vector_store_unit: directed and randomized transfers
// checked cycle by cycle against an element/address model derived from the vector.
module tb_vector_store_unit;

    localparam int NUM = 16;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [31:0]  base_addr;
    logic [127:0] vec_in;
    logic         busy;
    logic         done;
    logic         mem_we;
    logic [31:0]  mem_addr;
    logic [7:0]   mem_wdata;
    logic         mem_ready;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    vector_store_unit dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .base_addr (base_addr),
        .vec_in    (vec_in),
        .busy      (busy),
        .done      (done),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_ready (mem_ready)
    );

    task automatic check_output(input string tag, input logic [63:0] actual, input logic [63:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, actual, expected);
        end
    endtask

    // Element idx of a packed vector, element 0 being the most significant byte.
    function automatic logic [7:0] elem_of(input logic [127:0] v, input int idx);
        logic [127:0] t;
        t = v >> (8 * (NUM - 1 - idx));
        return t[7:0];
    endfunction

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic check_idle(input string tag);
        check_output({tag, "_we"},   64'(mem_we), 64'd0);
        check_output({tag, "_busy"}, 64'(busy),   64'd0);
        check_output({tag, "_done"}, 64'(done),   64'd0);
    endtask

    // Cycle 0 is the cycle in which start is presented; outputs are observed
    // 1 time unit after each rising edge, inputs for the next edge are set then.
    task automatic run_transfer(input logic [127:0] vec, input logic [31:0] base,
                                input int stall_elem, input int stall_len,
                                input bit random_ready, input int extra_start_cycle,
                                input int reset_cycle);
        int          idx;
        int          stalls;
        int          stall_left;
        bit          finished;
        logic [31:0] exp_addr;
        idx        = 0;
        stalls     = 0;
        stall_left = stall_len;
        finished   = 0;
        vec_in     = vec;
        base_addr  = base;
        start      = 1'b1;
        mem_ready  = 1'b1;
        for (int cyc = 1; cyc <= 300 && !finished; cyc++) begin
            next_cycle();
            start  = 1'b0;
            vec_in = ~vec;
            if (reset_cycle > 0 && cyc == reset_cycle + 1) begin
                check_idle("after_reset");
                check_output("after_reset_addr", 64'(mem_addr), 64'd0);
                rst = 1'b0;
                for (int k = 0; k < 4; k++) begin
                    next_cycle();
                    check_idle("post_reset_quiet");
                end
                finished = 1;
            end else if (idx < NUM) begin
                exp_addr = base + 32'(idx);
                check_output("we",   64'(mem_we),    64'd1);
                check_output("addr", 64'(mem_addr),  64'(exp_addr));
                check_output("data", 64'(mem_wdata), 64'(elem_of(vec, idx)));
                check_output("busy", 64'(busy),      64'd1);
                check_output("done_early", 64'(done), 64'd0);
                if (random_ready) begin
                    mem_ready = ($urandom_range(0, 3) != 0);
                end else begin
                    mem_ready = !(idx == stall_elem && stall_left > 0);
                end
                if (mem_ready) begin
                    idx++;
                end else begin
                    stalls++;
                    if (!random_ready) stall_left--;
                end
                if (cyc == extra_start_cycle) begin
                    start     = 1'b1;
                    vec_in    = {$urandom, $urandom, $urandom, $urandom};
                    base_addr = ~base;
                end
                if (reset_cycle > 0 && cyc == reset_cycle) rst = 1'b1;
            end else begin
                check_output("done",      64'(done),   64'd1);
                check_output("done_busy", 64'(busy),   64'd1);
                check_output("done_we",   64'(mem_we), 64'd0);
                check_output("done_cycle", 64'(cyc),   64'(17 + stalls));
                mem_ready = $urandom_range(0, 1) != 0;
                next_cycle();
                check_idle("back_idle");
                finished = 1;
            end
        end
        if (!finished) check_output("timeout", 64'd0, 64'd1);
    endtask

    initial begin
        logic [127:0] rvec;
        logic [31:0]  rbase;
        rst       = 1'b1;
        start     = 1'b0;
        mem_ready = 1'b0;
        base_addr = '0;
        vec_in    = '0;
        next_cycle();
        next_cycle();
        check_idle("reset");
        check_output("reset_addr", 64'(mem_addr),  64'd0);
        check_output("reset_data", 64'(mem_wdata), 64'd0);
        rst = 1'b0;
        for (int i = 0; i < 10; i++) begin
            mem_ready = $urandom_range(0, 1) != 0;
            next_cycle();
            check_idle("idle");
        end

        // Reset must beat a simultaneous start.
        rst   = 1'b1;
        start = 1'b1;
        next_cycle();
        rst   = 1'b0;
        start = 1'b0;
        check_idle("rst_over_start");
        next_cycle();
        check_idle("rst_over_start_2");

        run_transfer(128'h00112233_44556677_8899AABB_CCDDEEFF, 32'h100, -1, 0, 0, -1, 0);
        run_transfer(128'h00112233_44556677_8899AABB_CCDDEEFF, 32'h100, 5, 3, 0, -1, 0);
        run_transfer(128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210, 32'hFFFF_FFFE, -1, 0, 0, -1, 0);
        run_transfer(128'hDEAD_BEEF_CAFE_F00D_1357_9BDF_2468_ACE0, 32'h2000, -1, 0, 0, 5, 0);
        run_transfer(128'hA5A5_5A5A_0F0F_F0F0_1111_2222_3333_4444, 32'h300, -1, 0, 0, -1, 8);
        run_transfer(128'h7766_5544_3322_1100_FFEE_DDCC_BBAA_9988, 32'h4440, -1, 0, 0, -1, 0);

        for (int t = 0; t < 8; t++) begin
            rvec  = {$urandom, $urandom, $urandom, $urandom};
            rbase = $urandom;
            if (t == 0) rbase = 32'hFFFF_FFF8;
            run_transfer(rvec, rbase, -1, 0, 1, (t % 2 == 0) ? int'($urandom_range(1, 15)) : -1, 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/vector_store_unit.md
Name: vector_store_unit

Overview:
- Sequential consumer of the 128-bit packed matrix result produced by the SIMD matrix/dot-product datapath.
- On a start pulse it latches one packed vector and a base address, then writes the vector's elements one per accepted beat to a byte-wide data memory.
- It is the memory-side "other end" of the packed-vector interface: it unpacks the vector and stores it, where the datapath loads and packs.
- It sits between the vector execute stage and the data memory write port.

Parameters:
- WIDTH_V, 128, packed vector width in bits.
- BITS_INDEX, 8, element width in bits; also the memory data width.
- ADDR_W, 32, memory address width.
- Derived localparam NUM_ELEMENTS = WIDTH_V / BITS_INDEX (16).

Ports:
- clk  input  1  single system clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  request to store vec_in at base_addr; sampled only in IDLE.
- base_addr  input  ADDR_W  address of element 0.
- vec_in  input  WIDTH_V  packed vector; element idx occupies bits [BITS_INDEX*(NUM_ELEMENTS-idx)-1 -: BITS_INDEX]; element 0 is the MSBs.
- busy  output  1  high while in WRITE or DONE.
- done  output  1  one-cycle pulse after the last element is accepted.
- mem_we  output  1  write request to memory.
- mem_addr  output  ADDR_W  write address.
- mem_wdata  output  BITS_INDEX  write data.
- mem_ready  input  1  memory accepts the current write when mem_we && mem_ready at a rising edge.

Behaviour:
- Reset (synchronous; rst high at an edge):
  - state=IDLE, busy=0, done=0, mem_we=0, mem_addr=0, mem_wdata=0, element counter=0.
  - Reset mid-operation abandons the transfer; mem_we is low from the next cycle and no done pulse is produced.
  - rst has priority over start and mem_ready.
- States: IDLE, WRITE, DONE. All outputs are registered.
- IDLE:
  - On start=1, latch vec_in and base_addr, set counter=0, and go to WRITE.
  - In the same edge, load mem_addr=base_addr, mem_wdata=element 0, mem_we=1.
  - The first write is therefore presented in the cycle after start.
- WRITE:
  - mem_we=1 throughout. mem_addr = base + counter, mem_wdata = element[counter].
  - Accept (mem_ready=1) with counter < NUM_ELEMENTS-1: counter+1, mem_addr+1, mem_wdata = next element.
  - Accept with counter == NUM_ELEMENTS-1: mem_we=0, go to DONE.
  - mem_ready=0 stalls: mem_addr, mem_wdata and mem_we are held stable; a stall has no cycle limit.
- DONE: done=1 for exactly one cycle, busy=1, then IDLE.
- start while busy: ignored. There is no queuing, and the latched vector is unaffected by changes on vec_in.
- Latency with mem_ready tied high:
  - start at cycle 0 → writes on cycles 1..16 → done at cycle 17 → IDLE at cycle 18.
  - A new start is accepted at cycle 18.
- Address arithmetic: modulo 2^ADDR_W; wrap from all-ones to 0 is legal and silent.
- Element data: passed unmodified; no sign or width conversion.
- Unpacking: implemented as a shift register that shifts the latched vector left by BITS_INDEX per accepted beat, or as an indexed mux. Both are acceptable; the observable outputs are identical.

Decomposition:
- Shared package simd_pkg holds:
  - WIDTH_V, BITS_INDEX, NUM_ELEMENTS;
  - the store state enum typedef (IDLE, WRITE, DONE);
  - an element typedef logic [BITS_INDEX-1:0].
- One sub-module is natural: vector_unpack_shift, a loadable left-shift register that outputs the MSB element; it is reusable for a future load path.
- The FSM and counter stay in vector_store_unit.

Test Plan:
- Reset, then idle: all outputs 0; start=0 for 10 cycles → mem_we stays 0.
- start with vec_in=128'h00112233_44556677_8899AABB_CCDDEEFF, base_addr=0x100, mem_ready=1:
  - writes (0x100,0x00), (0x101,0x11) … (0x10F,0xFF) on cycles 1..16;
  - done pulse on cycle 17.
- Same vector, mem_ready low for 3 cycles at element 5: addr 0x105 / data 0x55 held for 4 cycles; done at cycle 20.
- base_addr=0xFFFFFFFE: addresses FFFFFFFE, FFFFFFFF, 0, 1 … D; no errors.
- Second start pulse at cycle 5 with a different vector: ignored; data remains from the first vector; exactly one done.
- rst asserted at cycle 8 mid-transfer: from cycle 9 mem_we=0, busy=0, no done; a new start then writes element 0 of the new vector at the new base.
